// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with HI/LO registers
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset; aborts any operation in progress
//   start        request, sampled only while idle
//   op           000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO
//   dataA        multiplicand / dividend / MTHI-MTLO source
//   dataB        multiplier / divisor
//   busy         high while an iterative operation is in progress
//   done         one-cycle pulse after HI/LO have been updated
//   div_by_zero  valid with done; set only for DIV/DIVU with dataB == 0
//   hi, lo       HI and LO registers
module mult_div_unit #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [WORD_LENGTH-1:0] dataA,
    input  logic [WORD_LENGTH-1:0] dataB,
    output logic                   busy,
    output logic                   done,
    output logic                   div_by_zero,
    output logic [WORD_LENGTH-1:0] hi,
    output logic [WORD_LENGTH-1:0] lo
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    // acc holds {partial product high, multiplier/product low} during MUL
    // and {partial remainder, dividend/quotient} during DIV.
    logic [2*W-1:0]    acc;
    logic [W-1:0]      opb;
    logic              sign_a;
    logic              sign_b;
    logic              is_signed;
    logic              is_div;

    logic              signed_op;
    logic [W-1:0]      abs_a;
    logic [W-1:0]      abs_b;
    logic [W:0]        mul_sum;
    logic [W:0]        div_shift;
    logic [W:0]        div_trial;
    logic              neg_res;
    logic [2*W-1:0]    prod_fix;
    logic [W-1:0]      quo_fix;
    logic [W-1:0]      rem_fix;
    logic              last_iter;

    assign busy = (state != S_IDLE);

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        // Negating the most negative value yields the same bit pattern, which
        // is exactly its unsigned magnitude.
        abs_a = (signed_op && dataA[W-1]) ? (~dataA + 1'b1) : dataA;
        abs_b = (signed_op && dataB[W-1]) ? (~dataB + 1'b1) : dataB;

        // Shift-add: add the multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
        mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opb : {W{1'b0}})};

        // Restoring division: bring the next dividend bit into the remainder and
        // try subtracting the divisor; a clear borrow bit means it fits.
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_trial = div_shift - {1'b0, opb};

        neg_res  = is_signed && (sign_a ^ sign_b);
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        quo_fix  = neg_res ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        rem_fix  = (is_signed && sign_a) ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];

        last_iter = (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            is_signed   <= 1'b0;
            is_div      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULTU, OP_MULT: begin
                                acc       <= {{W{1'b0}}, abs_a};
                                opb       <= abs_b;
                                sign_a    <= signed_op && dataA[W-1];
                                sign_b    <= signed_op && dataB[W-1];
                                is_signed <= signed_op;
                                is_div    <= 1'b0;
                                cnt       <= '0;
                                state     <= S_MUL;
                            end
                            OP_DIVU, OP_DIV: begin
                                if (dataB == '0) begin
                                    // No iteration: result is fixed and flagged.
                                    hi          <= dataA;
                                    lo          <= '1;
                                    done        <= 1'b1;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    acc       <= {{W{1'b0}}, abs_a};
                                    opb       <= abs_b;
                                    sign_a    <= signed_op && dataA[W-1];
                                    sign_b    <= signed_op && dataB[W-1];
                                    is_signed <= signed_op;
                                    is_div    <= 1'b1;
                                    cnt       <= '0;
                                    state     <= S_DIV;
                                end
                            end
                            OP_MTHI: begin
                                hi   <= dataA;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= dataA;
                                done <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[W-1:1]};
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (!div_trial[W]) begin
                        acc <= {div_trial[W-1:0], acc[W-2:0], 1'b1};
                    end else begin
                        acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.WORD_LENGTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .dataA       (dataA),
        .dataB       (dataB),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a request and let the start edge (E0) pass; returns 1 time unit after E0.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        dataA = a;
        dataB = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // n counts edges with E0 as edge 1; bcnt counts samples with busy high before done.
    task automatic wait_done(output int n, output int bcnt, output bit ok);
        n    = 1;
        bcnt = 0;
        ok   = 1'b0;
        while (!ok && n < 100) begin
            if (done) begin
                ok = 1'b1;
            end else begin
                if (busy) bcnt++;
                @(posedge clk);
                #1;
                n++;
            end
        end
    endtask

    initial begin
        int  n;
        int  bcnt;
        bit  ok;
        int  extra;
        bit  iter;

        vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{3'b000, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 1'b0};
        vecs[4]  = '{3'b001, 32'h0000_0005, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0};
        vecs[5]  = '{3'b010, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[6]  = '{3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[8]  = '{3'b011, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{3'b010, 32'd3,         32'd10,        32'd3,         32'd0,         1'b0};
        vecs[11] = '{3'b011, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[12] = '{3'b010, 32'd0,         32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        dataA = '0;
        dataB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        check("reset_dbz", 64'(div_by_zero), 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // MTHI then MTLO on consecutive edges
        op = 3'b100; dataA = 32'h1234_5678; start = 1'b1;
        @(posedge clk);
        #1;
        check("mthi_done", 64'(done), 64'h1);
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_busy", 64'(busy), 64'h0);
        op = 3'b101; dataA = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mtlo_done", 64'(done), 64'h1);
        check("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        check("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
        check("mtlo_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        check("mt_done_drop", 64'(done), 64'h0);

        // Illegal ops do nothing
        for (int k = 6; k < 8; k++) begin
            launch(3'(k), 32'hDEAD_BEEF, 32'h1);
            check("illegal_done", 64'(done), 64'h0);
            check("illegal_busy", 64'(busy), 64'h0);
            check("illegal_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        end

        // Table-driven operations
        for (int i = 0; i < 13; i++) begin
            iter = !vecs[i].dbz;
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            // operands may change after the start edge
            op    = 3'b111;
            dataA = 32'h5A5A_5A5A;
            dataB = 32'h0;
            wait_done(n, bcnt, ok);
            check("done_seen", 64'(ok), 64'h1);
            check("vec_hi", 64'(hi), 64'(vecs[i].hi));
            check("vec_lo", 64'(lo), 64'(vecs[i].lo));
            check("vec_dbz", 64'(div_by_zero), 64'(vecs[i].dbz));
            check("vec_latency", 64'(n), iter ? 64'd34 : 64'd1);
            check("vec_busy_cycles", 64'(bcnt), iter ? 64'd33 : 64'd0);
            check("vec_busy_at_done", 64'(busy), 64'h0);
            @(posedge clk);
            #1;
            check("vec_done_pulse", 64'(done), 64'h0);
            check("vec_dbz_pulse", 64'(div_by_zero), 64'h0);
        end

        // Start while busy is ignored
        launch(3'b000, 32'd6, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        op = 3'b010; dataA = 32'd100; dataB = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, bcnt, ok);
        check("ignore_done_seen", 64'(ok), 64'h1);
        check("ignore_result", {hi, lo}, 64'd42);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("ignore_no_second_op", 64'(extra), 64'h0);

        // Back-to-back: new start issued in the cycle done is high
        launch(3'b000, 32'd6, 32'd7);
        wait_done(n, bcnt, ok);
        check("b2b_first", {hi, lo}, 64'd42);
        launch(3'b010, 32'd100, 32'd7);
        wait_done(n, bcnt, ok);
        check("b2b_done_seen", 64'(ok), 64'h1);
        check("b2b_second", {hi, lo}, {32'd2, 32'd14});
        check("b2b_latency", 64'(n), 64'd34);

        // Reset in the middle of an iteration
        launch(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #1;
        check("midop_busy", 64'(busy), 64'h1);
        reset = 1'b1;
        start = 1'b1;
        op    = 3'b100;
        dataA = 32'h7777_7777;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_hilo", {hi, lo}, 64'h0);
        check("abort_done", 64'(done), 64'h0);
        reset = 1'b0;
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("abort_quiet", 64'(extra), 64'h0);
        check("abort_hilo_held", {hi, lo}, 64'h0);

        launch(3'b010, 32'd9, 32'd3);
        wait_done(n, bcnt, ok);
        check("post_reset_done_seen", 64'(ok), 64'h1);
        check("post_reset_divu", {hi, lo}, {32'd0, 32'd3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
